// File: rtl/svi_arb_pkg.sv
// Shared types and helpers for the stream arbiter: FSM states, arbitration
// modes and the channel-index width rule.
package svi_arb_pkg;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        MODE_RR    = 1'b0,
        MODE_FIXED = 1'b1
    } mode_e;

    // A single channel still needs a 1-bit index so o_ch_id is never zero-width.
    function automatic int ch_w(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/svi_interfaces.sv
// Valid/ready stream interface shared by all stream-based blocks.
interface I_stream #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport Src (output valid, output data, input ready);
    modport Snk (input valid, input data, output ready);
endinterface

// File: rtl/svi_rr_pick.sv
// Combinational channel picker: rotates a doubled request vector so the search
// starts after the pointer (or at 0 in fixed mode) and takes the first request.
module svi_rr_pick
    import svi_arb_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = ch_w(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    input  mode_e           mode,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] idx
);

    localparam logic [CH_W:0]   N_CH_EXT = (CH_W + 1)'(N_CH);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);

    logic [CH_W-1:0]   start_s;
    logic [2*N_CH-1:0] dbl_s;
    logic [N_CH-1:0]   rot_s;
    logic [CH_W-1:0]   off_s;
    logic [CH_W:0]     sum_s;
    logic              found_s;

    // Search start, rotation, lowest-set-bit encode and un-rotation.
    always_comb begin
        if (mode == MODE_FIXED || ptr == LAST_CH) begin
            start_s = '0;
        end else begin
            start_s = ptr + CH_W'(1'b1);
        end

        dbl_s = {req, req} >> start_s;
        rot_s = dbl_s[N_CH-1:0];

        // Descending scan so the lowest set bit is the last one written.
        off_s = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? CH_W'(i) : off_s;
        end
        found_s = |rot_s;

        sum_s = {1'b0, start_s} + {1'b0, off_s};
        if (sum_s >= N_CH_EXT) begin
            idx = CH_W'(sum_s - N_CH_EXT);
        end else begin
            idx = CH_W'(sum_s);
        end

        if (found_s) begin
            grant = N_CH'(1'b1) << idx;
        end else begin
            grant = '0;
        end
    end

endmodule

// File: rtl/svi_stream_arbiter.sv
// Merges an array of valid/ready streams into one registered output stream with
// round-robin or fixed-priority arbitration and bounded burst locking.
module svi_stream_arbiter
    import svi_arb_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int N_CH      = 4,
    parameter  int BURST_MAX = 4,
    localparam int CH_W      = ch_w(N_CH)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    I_stream.Snk            p_in [N_CH-1:0],
    I_stream.Src            p_out,
    input  logic            i_prio_mode,
    input  logic [N_CH-1:0] i_ch_en,
    output logic [CH_W-1:0] o_ch_id
);

    localparam logic [7:0]      BURST_LAST = 8'(BURST_MAX);
    localparam logic            BURST_EN   = (BURST_MAX > 32'sd1);
    localparam logic [CH_W-1:0] LAST_CH    = CH_W'(N_CH - 1);

    logic [N_CH-1:0]  valid_s;
    logic [N_CH-1:0]  req_s;
    logic [N_CH-1:0]  pick_grant_s;
    logic [N_CH-1:0]  grant_s;
    logic [N_CH-1:0]  ready_s;
    logic [WIDTH-1:0] data_s [N_CH];
    logic [CH_W-1:0]  pick_idx_s;
    logic [CH_W-1:0]  sel_idx_s;
    logic             load_en_s;
    logic             rearb_s;
    logic             xfer_s;

    state_t           state_r;
    state_t           state_n_s;
    logic [CH_W-1:0]  ptr_r;
    logic [CH_W-1:0]  ptr_n_s;
    logic [CH_W-1:0]  lock_r;
    logic [CH_W-1:0]  lock_n_s;
    logic [7:0]       cnt_r;
    logic [7:0]       cnt_n_s;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [CH_W-1:0]  ch_id_r;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign valid_s[k]    = p_in[k].valid;
        assign data_s[k]     = p_in[k].data;
        assign p_in[k].ready = ready_s[k];
    end

    assign load_en_s = !out_valid_r || p_out.ready;
    assign req_s     = valid_s & i_ch_en;

    svi_rr_pick #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_pick (
        .req   (req_s),
        .ptr   (ptr_r),
        .mode  (mode_e'(i_prio_mode)),
        .grant (pick_grant_s),
        .idx   (pick_idx_s)
    );

    // Grant selection, input handshake and next-state / burst bookkeeping.
    always_comb begin
        rearb_s   = 1'b1;
        grant_s   = '0;
        sel_idx_s = pick_idx_s;
        state_n_s = state_r;
        ptr_n_s   = ptr_r;
        lock_n_s  = lock_r;
        cnt_n_s   = cnt_r;

        // A stalled output keeps the lock; an idle locked source releases it
        // in the same cycle so another channel can load without a bubble.
        case (state_r)
            ARB:     rearb_s = 1'b1;
            HOLD:    rearb_s = !i_ch_en[lock_r] || (load_en_s && !valid_s[lock_r]);
            default: rearb_s = 1'b1;
        endcase

        if (rearb_s) begin
            grant_s   = pick_grant_s;
            sel_idx_s = pick_idx_s;
        end else begin
            grant_s   = N_CH'(1'b1) << lock_r;
            sel_idx_s = lock_r;
        end

        if (i_rst) begin
            ready_s = '0;
        end else begin
            ready_s = grant_s & i_ch_en & {N_CH{load_en_s}};
        end
        xfer_s = |(ready_s & valid_s);

        if (xfer_s && rearb_s) begin
            ptr_n_s   = sel_idx_s;
            lock_n_s  = sel_idx_s;
            cnt_n_s   = 8'd1;
            state_n_s = BURST_EN ? HOLD : ARB;
        end else if (xfer_s) begin
            cnt_n_s   = cnt_r + 8'd1;
            state_n_s = (cnt_n_s == BURST_LAST) ? ARB : HOLD;
        end else if (rearb_s) begin
            state_n_s = ARB;
        end else begin
            state_n_s = HOLD;
        end
    end

    // Arbitration state and the single-entry output holding register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= ARB;
            ptr_r       <= LAST_CH;
            lock_r      <= '0;
            cnt_r       <= 8'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            ch_id_r     <= '0;
        end else begin
            state_r <= state_n_s;
            ptr_r   <= ptr_n_s;
            lock_r  <= lock_n_s;
            cnt_r   <= cnt_n_s;
            if (xfer_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= data_s[sel_idx_s];
                ch_id_r     <= sel_idx_s;
            end else if (p_out.ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign p_out.valid = out_valid_r;
    assign p_out.data  = out_data_r;
    assign o_ch_id     = ch_id_r;

endmodule
